// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grant and command mux for the SDRAM controller.
// Holds the command pins on the init sequencer until init_end_i. After that it
// grants auto-refresh, write or read (in that priority order) one at a time. It
// then waits for the matching *_end_i before it arbitrates again.
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   init_* / aref_* / wr_* / rd_*  requester handshakes and command fields
//   aref_en_o, wr_en_o, rd_en_o    one-cycle start strobes on grant
//   sdram_*_o                      SDRAM command, bank, address and DQ drive
module sdram_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              init_end_i,
  input  logic [3:0]        init_cmd_i,
  input  logic [1:0]        init_ba_i,
  input  logic [ADDR_W-1:0] init_addr_i,
  input  logic              aref_req_i,
  input  logic              aref_end_i,
  input  logic [3:0]        aref_cmd_i,
  input  logic [1:0]        aref_ba_i,
  input  logic [ADDR_W-1:0] aref_addr_i,
  input  logic              wr_req_i,
  input  logic              wr_end_i,
  input  logic [3:0]        wr_cmd_i,
  input  logic [1:0]        wr_ba_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              wr_sdram_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_req_i,
  input  logic              rd_end_i,
  input  logic [3:0]        rd_cmd_i,
  input  logic [1:0]        rd_ba_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              aref_en_o,
  output logic              wr_en_o,
  output logic              rd_en_o,
  output logic              sdram_cke_o,
  output logic              sdram_cs_n_o,
  output logic              sdram_ras_n_o,
  output logic              sdram_cas_n_o,
  output logic              sdram_we_n_o,
  output logic [1:0]        sdram_ba_o,
  output logic [ADDR_W-1:0] sdram_addr_o,
  output logic [DATA_W-1:0] sdram_dq_out_o,
  output logic              sdram_dq_oe_o
);

  localparam logic [3:0] CmdNop = 4'b0111;

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StArbit = 3'd1,
    StAref  = 3'd2,
    StWrite = 3'd3,
    StRead  = 3'd4
  } state_e;

  state_e state_q;
  logic   aref_en_q, wr_en_q, rd_en_q;
  logic [3:0] cmd;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StInit;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      // Strobes default low so each one lasts exactly the first granted cycle.
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      case (state_q)
        StInit: begin
          if (init_end_i) state_q <= StArbit;
        end
        StArbit: begin
          if (aref_req_i) begin
            state_q   <= StAref;
            aref_en_q <= 1'b1;
          end else if (wr_req_i) begin
            state_q <= StWrite;
            wr_en_q <= 1'b1;
          end else if (rd_req_i) begin
            state_q <= StRead;
            rd_en_q <= 1'b1;
          end
        end
        // Only the owner's end pulse releases the bus; others are ignored.
        StAref: begin
          if (aref_end_i) state_q <= StArbit;
        end
        StWrite: begin
          if (wr_end_i) state_q <= StArbit;
        end
        StRead: begin
          if (rd_end_i) state_q <= StArbit;
        end
        default: state_q <= StArbit;
      endcase
    end
  end

  // Command mux works straight off the registered state, with no extra stage.
  always_comb begin
    cmd          = CmdNop;
    sdram_ba_o   = 2'b11;
    sdram_addr_o = '1;
    case (state_q)
      StInit: begin
        cmd          = init_cmd_i;
        sdram_ba_o   = init_ba_i;
        sdram_addr_o = init_addr_i;
      end
      StAref: begin
        cmd          = aref_cmd_i;
        sdram_ba_o   = aref_ba_i;
        sdram_addr_o = aref_addr_i;
      end
      StWrite: begin
        cmd          = wr_cmd_i;
        sdram_ba_o   = wr_ba_i;
        sdram_addr_o = wr_addr_i;
      end
      StRead: begin
        cmd          = rd_cmd_i;
        sdram_ba_o   = rd_ba_i;
        sdram_addr_o = rd_addr_i;
      end
      default: ;
    endcase
  end

  assign sdram_cs_n_o   = cmd[3];
  assign sdram_ras_n_o  = cmd[2];
  assign sdram_cas_n_o  = cmd[1];
  assign sdram_we_n_o   = cmd[0];
  assign sdram_cke_o    = 1'b1;
  assign sdram_dq_out_o = wr_data_i;
  assign sdram_dq_oe_o  = (state_q == StWrite) && wr_sdram_en_i;
  assign aref_en_o      = aref_en_q;
  assign wr_en_o        = wr_en_q;
  assign rd_en_o        = rd_en_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic init_end;
  logic [3:0] init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0] init_ba, aref_ba, wr_ba, rd_ba;
  logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en;
  logic [15:0] wr_data;
  logic aref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n, dq_oe;
  logic [1:0] ba;
  logic [12:0] addr;
  logic [15:0] dq_out;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (0 init, 1 idle, 2 refresh, 3 write, 4 read)
  // and which start strobe (0 none, 1 aref, 2 wr, 3 rd) is currently showing.
  int m_owner;
  int m_strobe;

  always #5 clk = ~clk;

  sdram_arbiter #(.DATA_W(16), .ADDR_W(13)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .init_end_i(init_end),
    .init_cmd_i(init_cmd), .init_ba_i(init_ba), .init_addr_i(init_addr),
    .aref_req_i(aref_req), .aref_end_i(aref_end), .aref_cmd_i(aref_cmd),
    .aref_ba_i(aref_ba), .aref_addr_i(aref_addr),
    .wr_req_i(wr_req), .wr_end_i(wr_end), .wr_cmd_i(wr_cmd), .wr_ba_i(wr_ba),
    .wr_addr_i(wr_addr), .wr_sdram_en_i(wr_sdram_en), .wr_data_i(wr_data),
    .rd_req_i(rd_req), .rd_end_i(rd_end), .rd_cmd_i(rd_cmd), .rd_ba_i(rd_ba),
    .rd_addr_i(rd_addr),
    .aref_en_o(aref_en), .wr_en_o(wr_en), .rd_en_o(rd_en), .sdram_cke_o(cke),
    .sdram_cs_n_o(cs_n), .sdram_ras_n_o(ras_n), .sdram_cas_n_o(cas_n),
    .sdram_we_n_o(we_n), .sdram_ba_o(ba), .sdram_addr_o(addr),
    .sdram_dq_out_o(dq_out), .sdram_dq_oe_o(dq_oe)
  );

  logic [39:0] obs;
  assign obs = {cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq_out, dq_oe, aref_en, wr_en, rd_en};

  function automatic logic [39:0] exp_vec();
    logic [3:0] c;
    logic [1:0] b;
    logic [12:0] a;
    c = 4'b0111;
    b = 2'b11;
    a = 13'h1fff;
    if (m_owner == 0) begin c = init_cmd; b = init_ba; a = init_addr; end
    if (m_owner == 2) begin c = aref_cmd; b = aref_ba; a = aref_addr; end
    if (m_owner == 3) begin c = wr_cmd;   b = wr_ba;   a = wr_addr;   end
    if (m_owner == 4) begin c = rd_cmd;   b = rd_ba;   a = rd_addr;   end
    return {1'b1, c, b, a, wr_data, (m_owner == 3) && wr_sdram_en,
            m_strobe == 1, m_strobe == 2, m_strobe == 3};
  endfunction

  // Advance the model on a clock edge from the inputs seen at that edge.
  task automatic tick();
    logic [2:0] reqs;
    logic [2:0] ends;
    @(posedge clk);
    reqs = {aref_req, wr_req, rd_req};
    ends = {aref_end, wr_end, rd_end};
    m_strobe = 0;
    if (!rst_n) begin
      m_owner = 0;
    end else if (m_owner == 0) begin
      if (init_end) m_owner = 1;
    end else if (m_owner == 1) begin
      for (int s = 0; s < 3; s++) begin
        if (m_strobe == 0 && reqs[2-s]) begin
          m_owner = s + 2;
          m_strobe = s + 1;
        end
      end
    end else if (ends[4-m_owner]) begin
      m_owner = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init_end = 1'b0;
    init_cmd = 4'b0010;
    init_ba = 2'd1;
    init_addr = 13'h0123;
    #2;
    m_owner = 0;
    m_strobe = 0;
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", obs, exp_vec());
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL init_hold cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    init_end = 1'b1;
    tick();
    checks++;
    if ({cs_n, ras_n, cas_n, we_n, ba, addr} !== {4'b0111, 2'b11, 13'h1fff}) begin
      errors++;
      $display("FAIL init_to_arbit_nop: got %b %h %h expected 0111 3 1fff",
               {cs_n, ras_n, cas_n, we_n}, ba, addr);
    end
  endtask

  task automatic test_priority();
    aref_req = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    aref_cmd = 4'b0001;
    tick();
    checks++;
    if ({aref_en, wr_en, rd_en} !== 3'b100 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL priority_grant: got %h expected %h", obs, exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (aref_en !== 1'b0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL aref_hold cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_aref_then_write();
    aref_end = 1'b1;
    aref_req = 1'b0;
    tick();
    aref_end = 1'b0;
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL aref_release: got %h expected %h", obs, exp_vec());
    end
    wr_cmd = 4'b0100;
    wr_ba = 2'd2;
    wr_addr = 13'h0abc;
    tick();
    checks++;
    if (wr_en !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL write_grant: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_write_data();
    wr_sdram_en = 1'b1;
    wr_data = 16'ha5a5;
    aref_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dq_oe !== 1'b1 || dq_out !== 16'ha5a5 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL write_data cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    wr_end = 1'b1;
    wr_req = 1'b0;
    tick();
    wr_end = 1'b0;
    wr_sdram_en = 1'b0;
    tick();
    checks++;
    if (aref_en !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL aref_after_write: got %h expected %h", obs, exp_vec());
    end
    aref_end = 1'b1;
    aref_req = 1'b0;
    tick();
    aref_end = 1'b0;
    rd_cmd = 4'b0101;
    tick();
    checks++;
    if (rd_en !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL read_grant: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_read_spurious();
    wr_sdram_en = 1'b1;
    aref_end = 1'b1;
    tick();
    checks++;
    if (dq_oe !== 1'b0 || {cs_n, ras_n, cas_n, we_n} !== 4'b0101 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL spurious_end_ignored: got %h expected %h", obs, exp_vec());
    end
    rd_end = 1'b1;
    rd_req = 1'b0;
    tick();
    aref_end = 1'b0;
    rd_end = 1'b0;
    checks++;
    if (dq_oe !== 1'b0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL read_release: got %h expected %h", obs, exp_vec());
    end
    wr_sdram_en = 1'b0;
  endtask

  task automatic test_reset_midwrite();
    wr_req = 1'b1;
    tick();
    wr_sdram_en = 1'b1;
    tick();
    checks++;
    if (dq_oe !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL pre_reset_write: got %h expected %h", obs, exp_vec());
    end
    init_end = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_owner = 0;
    m_strobe = 0;
    checks++;
    if (dq_oe !== 1'b0 || wr_en !== 1'b0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset_midwrite: got %h expected %h", obs, exp_vec());
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL reinit_hold cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    init_end = 1'b1;
    tick();
    tick();
    checks++;
    if (wr_en !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL regrant_after_init: got %h expected %h", obs, exp_vec());
    end
    wr_end = 1'b1;
    wr_req = 1'b0;
    wr_sdram_en = 1'b0;
    tick();
    wr_end = 1'b0;
  endtask

  task automatic test_random();
    int dur;
    logic [2:0] req;
    logic [2:0] fin;
    dur = 0;
    req = 3'b000;
    for (int i = 0; i < 600; i++) begin
      fin = 3'b000;
      for (int s = 0; s < 3; s++) begin
        if (m_owner == s + 2) begin
          if (m_strobe != 0) begin
            dur = $urandom_range(0, 3);
          end else if (dur == 0) begin
            fin[s] = 1'b1;
            req[s] = 1'b0;
          end else begin
            dur--;
          end
        end else begin
          if (!req[s] && $urandom_range(0, 2) == 0) req[s] = 1'b1;
          if ($urandom_range(0, 7) == 0) fin[s] = 1'b1;
        end
      end
      {aref_req, wr_req, rd_req} = req;
      {aref_end, wr_end, rd_end} = fin;
      aref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
      init_cmd = 4'($urandom);
      aref_ba = 2'($urandom); wr_ba = 2'($urandom); rd_ba = 2'($urandom);
      aref_addr = 13'($urandom); wr_addr = 13'($urandom); rd_addr = 13'($urandom);
      wr_data = 16'($urandom);
      wr_sdram_en = 1'($urandom);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    m_owner = 0;
    m_strobe = 0;
    {aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en} = '0;
    {aref_cmd, wr_cmd, rd_cmd} = '0;
    {aref_ba, wr_ba, rd_ba} = '0;
    {aref_addr, wr_addr, rd_addr} = '0;
    wr_data = '0;
    test_reset();
    test_priority();
    test_aref_then_write();
    test_write_data();
    test_read_spurious();
    test_reset_midwrite();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
